pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline, sitting beside the stage registers. It forwards the nearest ready producer value to the decode-stage operands. It stalls decode on Tuse/Tnew conflicts and inserts a bubble into ID/EX. It owns a cycle-accurate multiply/divide busy timer, so MDU-dependent instructions stall without an external busy signal.

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order pipeline: operand bypass, Tuse/Tnew stalls, MDU busy timer.
// Optional HAZ_PERF_CNT_EN builds the saturating stall performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTG        = 3,
    parameter int unsigned AW          = 5,
    parameter int unsigned DW          = 32,
    parameter int unsigned TW          = 2,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        rs_addr_d,
    input  logic [AW-1:0]        rt_addr_d,
    input  logic [TW-1:0]        rs_tuse_d,
    input  logic [TW-1:0]        rt_tuse_d,
    input  logic [DW-1:0]        rs_grf_d,
    input  logic [DW-1:0]        rt_grf_d,
    input  logic                 md_use_d,
    input  logic [NSTG*AW-1:0]   dst_addr_s,
    input  logic [NSTG*TW-1:0]   tnew_s,
    input  logic [NSTG*DW-1:0]   fwd_data_s,
    input  logic                 md_start,
    input  logic                 md_is_div,
    output logic [DW-1:0]        rs_fwd_d,
    output logic [DW-1:0]        rt_fwd_d,
    output logic                 stall,
    output logic                 enable_PC,
    output logic                 enable_IF,
    output logic                 bubble_ID,
    output logic                 md_busy,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          md_stall_cnt
);

    localparam int unsigned CW = 8;

    typedef enum logic {S_IDLE, S_BUSY} md_state_t;

    md_state_t      r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           w_rs_haz, w_rt_haz;
    logic           w_data_haz, w_md_haz, w_stall_raw;

    // Nearest ready producer supplies the value; any younger-than-needed producer raises a hazard.
    function automatic logic [DW:0] resolve(
        input logic [AW-1:0]      addr,
        input logic [TW-1:0]      tuse,
        input logic [DW-1:0]      grf,
        input logic [NSTG*AW-1:0] dsts,
        input logic [NSTG*TW-1:0] tnews,
        input logic [NSTG*DW-1:0] datas
    );
        logic [DW-1:0] val;
        logic          haz;
        logic          found;
        logic [AW-1:0] d;
        logic [TW-1:0] t;
        val   = grf;
        haz   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            d = dsts[k*AW +: AW];
            t = tnews[k*TW +: TW];
            if (d != '0 && d == addr) begin
                if (!found && t == '0) val = datas[k*DW +: DW];
                found = 1'b1;
                if (tuse != '1 && t > tuse) haz = 1'b1;
            end
        end
        return {haz, val};
    endfunction

    assign {w_rs_haz, rs_fwd_d} = resolve(rs_addr_d, rs_tuse_d, rs_grf_d, dst_addr_s, tnew_s, fwd_data_s);
    assign {w_rt_haz, rt_fwd_d} = resolve(rt_addr_d, rt_tuse_d, rt_grf_d, dst_addr_s, tnew_s, fwd_data_s);

    assign md_busy     = (r_state == S_BUSY);
    assign w_data_haz  = w_rs_haz | w_rt_haz;
    assign w_md_haz    = md_use_d & (md_busy | md_start);
    assign w_stall_raw = w_data_haz | w_md_haz;

    // While reset is held the pipeline runs with ID/EX cleared and no stall.
    assign stall     = reset ? w_stall_raw : 1'b0;
    assign enable_PC = ~stall;
    assign enable_IF = ~stall;
    assign bubble_ID = reset ? w_stall_raw : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MDU timer: a start while busy is ignored since decode is already stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (md_start) begin
                    w_cnt_nxt   = md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_md_stall_cnt;

    // Saturating counters; a combined data+MDU stall counts once in stall_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt    <= '0;
            r_md_stall_cnt <= '0;
        end else begin
            if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_md_haz && r_md_stall_cnt != '1) r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`else
    assign stall_cnt    = '0;
    assign md_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, data/MDU stalls, async reset, counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int unsigned NSTG = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned TW   = 2;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [AW-1:0]       rs_addr_d, rt_addr_d;
    logic [TW-1:0]       rs_tuse_d, rt_tuse_d;
    logic [DW-1:0]       rs_grf_d, rt_grf_d;
    logic                md_use_d;
    logic [NSTG*AW-1:0]  dst_addr_s;
    logic [NSTG*TW-1:0]  tnew_s;
    logic [NSTG*DW-1:0]  fwd_data_s;
    logic                md_start, md_is_div;
    logic [DW-1:0]       rs_fwd_d, rt_fwd_d;
    logic                stall, enable_PC, enable_IF, bubble_ID, md_busy;
    logic [31:0]         stall_cnt, md_stall_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_s  = '0;
    logic [31:0] exp_m  = '0;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d),
        .rs_tuse_d(rs_tuse_d), .rt_tuse_d(rt_tuse_d),
        .rs_grf_d(rs_grf_d), .rt_grf_d(rt_grf_d),
        .md_use_d(md_use_d),
        .dst_addr_s(dst_addr_s), .tnew_s(tnew_s), .fwd_data_s(fwd_data_s),
        .md_start(md_start), .md_is_div(md_is_div),
        .rs_fwd_d(rs_fwd_d), .rt_fwd_d(rt_fwd_d),
        .stall(stall), .enable_PC(enable_PC), .enable_IF(enable_IF),
        .bubble_ID(bubble_ID), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stages();
        dst_addr_s = '0;
        tnew_s     = '0;
        fwd_data_s = '0;
    endtask

    task automatic set_stg(input int k, input logic [AW-1:0] d, input logic [TW-1:0] t,
                           input logic [DW-1:0] v);
        dst_addr_s[k*AW +: AW] = d;
        tnew_s[k*TW +: TW]     = t;
        fwd_data_s[k*DW +: DW] = v;
    endtask

    task automatic set_dec(input logic [AW-1:0] rs, input logic [TW-1:0] rsu, input logic [DW-1:0] rsg,
                           input logic [AW-1:0] rt, input logic [TW-1:0] rtu, input logic [DW-1:0] rtg);
        rs_addr_d = rs; rs_tuse_d = rsu; rs_grf_d = rsg;
        rt_addr_d = rt; rt_tuse_d = rtu; rt_grf_d = rtg;
    endtask

    // Check combinational outputs and counters, then advance one clock and update the counter model.
    task automatic step(input string tag, input logic [DW-1:0] ers, input logic [DW-1:0] ert,
                        input logic es, input logic em, input logic eb);
        #1;
        chk({tag, ":rs_fwd"}, rs_fwd_d, ers);
        chk({tag, ":rt_fwd"}, rt_fwd_d, ert);
        chk({tag, ":stall"}, 32'(stall), 32'(es));
        chk({tag, ":enable_PC"}, 32'(enable_PC), 32'(!es));
        chk({tag, ":enable_IF"}, 32'(enable_IF), 32'(!es));
        chk({tag, ":bubble_ID"}, 32'(bubble_ID), 32'(es));
        chk({tag, ":md_busy"}, 32'(md_busy), 32'(eb));
        chk({tag, ":stall_cnt"}, stall_cnt, exp_s);
        chk({tag, ":md_stall_cnt"}, md_stall_cnt, exp_m);
        @(posedge clk);
        if (PERF) begin
            if (es && exp_s != 32'hFFFF_FFFF) exp_s = exp_s + 32'd1;
            if (em && exp_m != 32'hFFFF_FFFF) exp_m = exp_m + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        md_use_d = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
        clr_stages();
        set_dec(5'd0, 2'd3, 32'h0, 5'd0, 2'd3, 32'h0);
        #1;
        chk("rst:stall", 32'(stall), 32'd0);
        chk("rst:enable_PC", 32'(enable_PC), 32'd1);
        chk("rst:enable_IF", 32'(enable_IF), 32'd1);
        chk("rst:bubble_ID", 32'(bubble_ID), 32'd1);
        chk("rst:md_busy", 32'(md_busy), 32'd0);
        chk("rst:stall_cnt", stall_cnt, 32'd0);
        chk("rst:md_stall_cnt", md_stall_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Ready producer at stage 0 forwards.
        set_stg(0, 5'd8, 2'd0, 32'h1234);
        set_dec(5'd8, 2'd1, 32'hAAAA, 5'd0, 2'd3, 32'h0);
        step("fwd_s0", 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);

        // Nearest producer not ready and too late: stall, GRF value passes through.
        clr_stages();
        set_stg(0, 5'd8, 2'd2, 32'h5555);
        set_stg(1, 5'd8, 2'd0, 32'h7777);
        set_dec(5'd0, 2'd3, 32'h0, 5'd8, 2'd1, 32'hBEEF);
        step("stall_s0", 32'h0, 32'hBEEF, 1'b1, 1'b0, 1'b0);

        // Register 0 never matches regardless of tnew.
        clr_stages();
        set_stg(0, 5'd0, 2'd3, 32'hDEAD);
        set_stg(1, 5'd0, 2'd3, 32'hDEAD);
        set_stg(2, 5'd0, 2'd3, 32'hDEAD);
        set_dec(5'd0, 2'd0, 32'h11, 5'd0, 2'd0, 32'h22);
        step("reg0", 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);

        // Forward from far stage and from stage 0 on separate operands.
        clr_stages();
        set_stg(0, 5'd9, 2'd0, 32'h99);
        set_stg(1, 5'd3, 2'd0, 32'h33);
        set_stg(2, 5'd8, 2'd0, 32'hCAFE);
        set_dec(5'd8, 2'd0, 32'h1, 5'd9, 2'd0, 32'h2);
        step("fwd_s2", 32'hCAFE, 32'h99, 1'b0, 1'b0, 1'b0);

        // Two ready matches: the nearest wins.
        clr_stages();
        set_stg(0, 5'd8, 2'd0, 32'h100);
        set_stg(1, 5'd8, 2'd0, 32'h200);
        set_dec(5'd8, 2'd0, 32'h1, 5'd8, 2'd2, 32'h2);
        step("nearest", 32'h100, 32'h100, 1'b0, 1'b0, 1'b0);

        // All-ones tuse never stalls.
        clr_stages();
        set_stg(0, 5'd8, 2'd3, 32'h400);
        set_dec(5'd8, 2'd3, 32'h5, 5'd0, 2'd3, 32'h6);
        step("tuse_unused", 32'h5, 32'h6, 1'b0, 1'b0, 1'b0);

        // tnew == tuse is not a hazard; not-ready nearest means GRF value.
        clr_stages();
        set_stg(0, 5'd8, 2'd1, 32'h500);
        set_dec(5'd8, 2'd1, 32'h7, 5'd0, 2'd3, 32'h8);
        step("tnew_eq_tuse", 32'h7, 32'h8, 1'b0, 1'b0, 1'b0);

        // Hazard from a non-nearest stage still stalls.
        clr_stages();
        set_stg(0, 5'd8, 2'd0, 32'h300);
        set_stg(2, 5'd8, 2'd2, 32'h301);
        set_dec(5'd8, 2'd1, 32'h9, 5'd0, 2'd3, 32'hA);
        step("far_haz", 32'h300, 32'hA, 1'b1, 1'b0, 1'b0);

        // rt hazard at stage 1.
        clr_stages();
        set_stg(1, 5'd12, 2'd2, 32'h600);
        set_dec(5'd0, 2'd3, 32'hB, 5'd12, 2'd0, 32'hC);
        step("rt_haz_s1", 32'hB, 32'hC, 1'b1, 1'b0, 1'b0);

        // Divide: 1 + 10 stall cycles, busy for 10.
        clr_stages();
        set_dec(5'd0, 2'd3, 32'h11, 5'd0, 2'd3, 32'h22);
        exp_m = '0;
        chk("md_cnt_pre_div", md_stall_cnt, 32'd0);
        md_start = 1'b1; md_is_div = 1'b1; md_use_d = 1'b1;
        step("div_start", 32'h11, 32'h22, 1'b1, 1'b1, 1'b0);
        md_start = 1'b0; md_is_div = 1'b0;
        for (int i = 0; i < 10; i++) step("div_busy", 32'h11, 32'h22, 1'b1, 1'b1, 1'b1);
        step("div_done", 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        chk("md_stall_cnt_div", md_stall_cnt, PERF ? 32'd11 : 32'd0);

        // Multiply, then asynchronous reset in the third busy cycle.
        md_start = 1'b1; md_use_d = 1'b1;
        step("mul_start", 32'h11, 32'h22, 1'b1, 1'b1, 1'b0);
        md_start = 1'b0; md_use_d = 1'b0;
        step("mul_busy1_nouse", 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
        md_use_d = 1'b1;
        step("mul_busy2", 32'h11, 32'h22, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mul_busy3", 32'(md_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst:md_busy", 32'(md_busy), 32'd0);
        chk("arst:stall", 32'(stall), 32'd0);
        chk("arst:enable_PC", 32'(enable_PC), 32'd1);
        chk("arst:enable_IF", 32'(enable_IF), 32'd1);
        chk("arst:bubble_ID", 32'(bubble_ID), 32'd1);
        chk("arst:stall_cnt", stall_cnt, 32'd0);
        chk("arst:md_stall_cnt", md_stall_cnt, 32'd0);
        exp_s = '0;
        exp_m = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst_idle", 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
        md_use_d = 1'b0;

        // Saturation of stall_cnt from a preloaded value.
        set_stg(0, 5'd8, 2'd2, 32'h700);
        set_dec(5'd8, 2'd0, 32'h13, 5'd0, 2'd3, 32'h14);
`ifdef HAZ_PERF_CNT_EN
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cnt;
        exp_s = 32'hFFFF_FFFD;
`endif
        for (int i = 0; i < 5; i++) step("sat", 32'h13, 32'h14, 1'b1, 1'b0, 1'b0);
        #1;
        chk("sat_final", stall_cnt, PERF ? 32'hFFFF_FFFF : 32'd0);
        chk("sat_md_cnt", md_stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
